// File: rtl/tile_boot_ctrl_if.sv
`default_nettype none
// ============================================================================
// tile_boot_ctrl_if : host-side control/status port of the tile boot sequencer
// Revision 1.0
// ============================================================================
interface tile_boot_ctrl_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 32
) ();
    logic              start_i;
    logic              start_ready_o;
    logic [ADDR_W-1:0] boot_addr_i;
    logic [CNT_W-1:0]  timeout_i;
    logic              clear_i;
    logic              busy_o;
    logic              done_o;
    logic              timeout_o;
    logic [DATA_W-1:0] exit_code_o;
    logic [CNT_W-1:0]  cycles_o;

    modport master (
        output start_i, boot_addr_i, timeout_i, clear_i,
        input  start_ready_o, busy_o, done_o, timeout_o, exit_code_o, cycles_o
    );

    modport slave (
        input  start_i, boot_addr_i, timeout_i, clear_i,
        output start_ready_o, busy_o, done_o, timeout_o, exit_code_o, cycles_o
    );
endinterface
`default_nettype wire

// File: rtl/tile_boot_ctrl.sv
`default_nettype none
// ============================================================================
// tile_boot_ctrl : boot / end-of-computation sequencer with watchdog for a tile core
// Revision 1.0
// ============================================================================
module tile_boot_ctrl #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int CNT_W    = 32,
    parameter int RST_HOLD = 4
) (
    input  wire logic              clk_i,
    input  wire logic              rst_i,
    tile_boot_ctrl_if.slave        host,
    output logic                   core_rst_o,
    output logic                   fetch_en_o,
    output logic [ADDR_W-1:0]      boot_addr_o,
    input  wire logic              eoc_valid_i,
    input  wire logic [DATA_W-1:0] eoc_code_i
);
    localparam int HOLD_W = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_HOLD    = 3'd1,
        S_RUN     = 3'd2,
        S_DONE    = 3'd3,
        S_TIMEOUT = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic [ADDR_W-1:0]   boot_addr_q, boot_addr_d;
    logic [CNT_W-1:0]    timeout_q, timeout_d;
    logic [CNT_W-1:0]    cycles_q, cycles_d;
    logic [DATA_W-1:0]   code_q, code_d;
    logic [CNT_W-1:0]    cyc_inc;

    // Saturating increment so a runaway core without watchdog never wraps the count
    assign cyc_inc = (&cycles_q) ? cycles_q : cycles_q + CNT_W'(1);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            hold_q      <= '0;
            boot_addr_q <= '0;
            timeout_q   <= '0;
            cycles_q    <= '0;
            code_q      <= '0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            boot_addr_q <= boot_addr_d;
            timeout_q   <= timeout_d;
            cycles_q    <= cycles_d;
            code_q      <= code_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        boot_addr_d = boot_addr_q;
        timeout_d   = timeout_q;
        cycles_d    = cycles_q;
        code_d      = code_q;
        unique case (state_q)
            S_IDLE: begin
                if (host.start_i) begin
                    boot_addr_d = host.boot_addr_i;
                    timeout_d   = host.timeout_i;
                    cycles_d    = '0;
                    code_d      = '0;
                    hold_d      = HOLD_W'(RST_HOLD - 1);
                    state_d     = S_HOLD;
                end
            end
            S_HOLD: begin
                if (hold_q == '0) begin
                    state_d = S_RUN;
                end else begin
                    hold_d = hold_q - HOLD_W'(1);
                end
            end
            S_RUN: begin
                // EOC takes priority over a watchdog expiry in the same cycle
                if (eoc_valid_i) begin
                    code_d  = eoc_code_i;
                    state_d = S_DONE;
                end else begin
                    cycles_d = cyc_inc;
                    if ((timeout_q != '0) && (cyc_inc == timeout_q)) begin
                        state_d = S_TIMEOUT;
                    end
                end
            end
            S_DONE, S_TIMEOUT: begin
                if (host.clear_i) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign core_rst_o         = (state_q == S_IDLE) || (state_q == S_HOLD) || (state_q == S_TIMEOUT);
    assign fetch_en_o         = (state_q == S_RUN);
    assign boot_addr_o        = boot_addr_q;
    assign host.start_ready_o = (state_q == S_IDLE);
    assign host.busy_o        = (state_q == S_HOLD) || (state_q == S_RUN);
    assign host.done_o        = (state_q == S_DONE);
    assign host.timeout_o     = (state_q == S_TIMEOUT);
    assign host.exit_code_o   = code_q;
    assign host.cycles_o      = cycles_q;
endmodule
`default_nettype wire

// File: tb/tb_tile_boot_ctrl.sv
`default_nettype none
// ============================================================================
// tb_tile_boot_ctrl : directed bench with completion scoreboard for tile_boot_ctrl
// Revision 1.0
// ============================================================================
module tb_tile_boot_ctrl;
    localparam int ADDR_W   = 32;
    localparam int DATA_W   = 32;
    localparam int CNT_W    = 32;
    localparam int RST_HOLD = 4;

    typedef struct {
        bit          is_to;
        logic [31:0] code;
        logic [31:0] cyc;
        logic [31:0] addr;
        bit          crst;
    } exp_t;

    logic              clk_i;
    logic              rst_i;
    logic              core_rst_o;
    logic              fetch_en_o;
    logic [ADDR_W-1:0] boot_addr_o;
    logic              eoc_valid_i;
    logic [DATA_W-1:0] eoc_code_i;

    int   n_vec = 0;
    int   n_err = 0;
    exp_t exp_q[$];

    tile_boot_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) hif ();

    tile_boot_ctrl #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W), .RST_HOLD(RST_HOLD)
    ) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .host       (hif),
        .core_rst_o (core_rst_o),
        .fetch_en_o (fetch_en_o),
        .boot_addr_o(boot_addr_o),
        .eoc_valid_i(eoc_valid_i),
        .eoc_code_i (eoc_code_i)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Monitor: pops an expectation on every rising completion (done or timeout)
    initial begin
        bit   prev_evt;
        bit   evt;
        exp_t e;
        prev_evt = 1'b0;
        forever begin
            @(negedge clk_i);
            evt      = (hif.done_o === 1'b1) || (hif.timeout_o === 1'b1);
            if (evt && !prev_evt) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL sb_unexpected: got completion, expected none");
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_done",     {63'd0, hif.done_o},    {63'd0, !e.is_to});
                    chk("sb_timeout",  {63'd0, hif.timeout_o}, {63'd0, e.is_to});
                    chk("sb_exit",     {32'd0, hif.exit_code_o}, {32'd0, e.code});
                    chk("sb_cycles",   {32'd0, hif.cycles_o},  {32'd0, e.cyc});
                    chk("sb_bootaddr", {32'd0, boot_addr_o},   {32'd0, e.addr});
                    chk("sb_core_rst", {63'd0, core_rst_o},    {63'd0, e.crst});
                    chk("sb_fetch_en", {63'd0, fetch_en_o},    64'd0);
                end
            end
            prev_evt = evt;
        end
    end

    // Caller must be at a negedge with the DUT in IDLE
    task automatic do_start(input logic [31:0] addr, input logic [31:0] to, input bit eoc_in_hold);
        chk("start_ready", {63'd0, hif.start_ready_o}, 64'd1);
        hif.start_i     = 1'b1;
        hif.boot_addr_i = addr;
        hif.timeout_i   = to;
        @(posedge clk_i);
        #1;
        hif.start_i     = 1'b0;
        hif.boot_addr_i = 32'h5555_5555;
        hif.timeout_i   = 32'd3;
        eoc_valid_i     = eoc_in_hold;
        eoc_code_i      = 32'hBAD0_0BAD;
        for (int k = 0; k < RST_HOLD; k++) begin
            @(negedge clk_i);
            chk($sformatf("hold%0d_rst_fetch_busy", k),
                {61'd0, core_rst_o, fetch_en_o, hif.busy_o}, 64'b101);
            if (k == 0) begin
                chk("hold_bootaddr", {32'd0, boot_addr_o}, {32'd0, addr});
                chk("hold_cycles_clr", {32'd0, hif.cycles_o}, 64'd0);
                chk("hold_exit_clr", {32'd0, hif.exit_code_o}, 64'd0);
            end
        end
        eoc_valid_i = 1'b0;
        eoc_code_i  = '0;
        @(negedge clk_i);
        chk("run_rst_fetch", {62'd0, core_rst_o, fetch_en_o}, 64'b01);
    endtask

    task automatic eoc_after(input int k, input logic [31:0] code);
        repeat (k) @(negedge clk_i);
        eoc_valid_i = 1'b1;
        eoc_code_i  = code;
        @(negedge clk_i);
        eoc_valid_i = 1'b0;
        eoc_code_i  = '0;
    endtask

    task automatic wait_evt(input int budget);
        int i;
        i = 0;
        while (!(hif.done_o === 1'b1 || hif.timeout_o === 1'b1) && i < budget) begin
            @(negedge clk_i);
            i++;
        end
        if (i >= budget) begin
            n_vec++;
            n_err++;
            $display("FAIL wait_evt: got no completion in %0d cycles, expected one", budget);
        end
    endtask

    task automatic do_clear();
        hif.clear_i = 1'b1;
        @(negedge clk_i);
        hif.clear_i = 1'b0;
        chk("clear_idle", {62'd0, hif.start_ready_o, core_rst_o}, 64'b11);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got hang, expected completion");
        $fatal(1, "bench timed out");
    end

    initial begin
        rst_i           = 1'b1;
        hif.start_i     = 1'b0;
        hif.boot_addr_i = '0;
        hif.timeout_i   = '0;
        hif.clear_i     = 1'b0;
        eoc_valid_i     = 1'b0;
        eoc_code_i      = '0;
        repeat (3) @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);

        chk("rst_start_ready", {63'd0, hif.start_ready_o}, 64'd1);
        chk("rst_core_rst",    {63'd0, core_rst_o}, 64'd1);
        chk("rst_fetch_en",    {63'd0, fetch_en_o}, 64'd0);
        chk("rst_status",      {61'd0, hif.busy_o, hif.done_o, hif.timeout_o}, 64'd0);
        chk("rst_bootaddr",    {32'd0, boot_addr_o}, 64'd0);
        chk("rst_exit",        {32'd0, hif.exit_code_o}, 64'd0);
        chk("rst_cycles",      {32'd0, hif.cycles_o}, 64'd0);

        // EOC while idle is ignored
        eoc_valid_i = 1'b1;
        eoc_code_i  = 32'h5;
        @(negedge clk_i);
        eoc_valid_i = 1'b0;
        chk("idle_eoc_ignored", {30'd0, hif.exit_code_o, hif.done_o, hif.start_ready_o}, 64'd1);

        // Reset in the middle of RUN, with an EOC pending in the same cycle
        do_start(32'h1000_0000, 32'd0, 1'b1);
        repeat (20) @(negedge clk_i);
        rst_i       = 1'b1;
        eoc_valid_i = 1'b1;
        eoc_code_i  = 32'h99;
        @(negedge clk_i);
        rst_i       = 1'b0;
        eoc_valid_i = 1'b0;
        chk("midrun_rst_rst_fetch", {62'd0, core_rst_o, fetch_en_o}, 64'b10);
        chk("midrun_rst_status",    {61'd0, hif.busy_o, hif.done_o, hif.timeout_o}, 64'd0);
        chk("midrun_rst_cycles",    {32'd0, hif.cycles_o}, 64'd0);
        chk("midrun_rst_exit",      {32'd0, hif.exit_code_o}, 64'd0);
        chk("midrun_rst_bootaddr",  {32'd0, boot_addr_o}, 64'd0);
        @(negedge clk_i);
        chk("midrun_rst_no_done",   {63'd0, hif.done_o}, 64'd0);

        // Normal EOC after 100 RUN cycles, with ignored start/clear during RUN
        exp_q.push_back('{is_to: 1'b0, code: 32'h0, cyc: 32'd100, addr: 32'hCC00_0080, crst: 1'b0});
        do_start(32'hCC00_0080, 32'd0, 1'b0);
        repeat (30) @(negedge clk_i);
        hif.start_i     = 1'b1;
        hif.boot_addr_i = 32'h0000_1234;
        hif.clear_i     = 1'b1;
        @(negedge clk_i);
        hif.start_i     = 1'b0;
        hif.clear_i     = 1'b0;
        chk("run_ignored_inputs",
            {29'd0, boot_addr_o, hif.busy_o, fetch_en_o, hif.done_o},
            {29'd0, 32'hCC00_0080, 3'b110});
        eoc_after(69, 32'h0);
        wait_evt(10);
        do_clear();

        // Watchdog at 50 cycles
        exp_q.push_back('{is_to: 1'b1, code: 32'h0, cyc: 32'd50, addr: 32'h2000_0040, crst: 1'b1});
        do_start(32'h2000_0040, 32'd50, 1'b0);
        wait_evt(200);
        do_clear();
        chk("post_timeout_clear", {63'd0, hif.timeout_o}, 64'd0);

        // EOC arriving one cycle after the watchdog fired is ignored
        exp_q.push_back('{is_to: 1'b1, code: 32'h0, cyc: 32'd10, addr: 32'h2000_0100, crst: 1'b1});
        do_start(32'h2000_0100, 32'd10, 1'b0);
        eoc_after(10, 32'hDEAD);
        wait_evt(10);
        @(negedge clk_i);
        chk("late_eoc_ignored", {31'd0, hif.exit_code_o, hif.timeout_o}, 64'd1);
        do_clear();

        // EOC in the 10th RUN cycle beats a 10-cycle watchdog
        exp_q.push_back('{is_to: 1'b0, code: 32'hDEAD, cyc: 32'd9, addr: 32'h2000_0200, crst: 1'b0});
        do_start(32'h2000_0200, 32'd10, 1'b0);
        eoc_after(9, 32'hDEAD);
        wait_evt(10);
        do_clear();

        // Back-to-back: start in the cycle right after clear
        exp_q.push_back('{is_to: 1'b0, code: 32'h7, cyc: 32'd5, addr: 32'h3000_0000, crst: 1'b0});
        do_start(32'h3000_0000, 32'd0, 1'b0);
        eoc_after(5, 32'h7);
        wait_evt(10);
        do_clear();

        @(negedge clk_i);
        chk("sb_queue_empty", exp_q.size(), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
